// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_arbiter
// Purpose  : Shares one UART buffer_writer between NUM_REQ debug requesters,
//            each with a one-deep request slot, and issues one write at a time.
// Option   : UART_TX_ARB_ROUND_ROBIN_EN selects round-robin instead of
//            fixed lowest-index-first priority.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
   parameter int NUM_REQ           = 3,
   parameter int DATA_OUT_BUS_SIZE = 56
) (
   input  logic                                   i_clk,
   input  logic                                   i_reset,
   input  logic [NUM_REQ-1:0]                     i_req,
   input  logic [NUM_REQ*DATA_OUT_BUS_SIZE-1:0]   i_data,
   input  logic                                   i_wr_finish,
   output logic                                   o_wr,
   output logic [DATA_OUT_BUS_SIZE-1:0]           o_wr_data,
   output logic [NUM_REQ-1:0]                     o_grant,
   output logic [NUM_REQ-1:0]                     o_done,
   output logic                                   o_busy,
   output logic [NUM_REQ-1:0]                     o_overrun
);

   localparam int IDXW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   state_t                         state;
   state_t                         state_nx;
   logic [NUM_REQ-1:0]             pending;
   logic [NUM_REQ-1:0]             pending_nx;
   logic [NUM_REQ-1:0]             overrun_nx;
   logic [DATA_OUT_BUS_SIZE-1:0]   hold [NUM_REQ];
   logic [IDXW-1:0]                winner;
   logic                           grant_fire;
   logic                           finish_fire;

`ifdef UART_TX_ARB_ROUND_ROBIN_EN
   logic [IDXW-1:0]                last_grant;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         last_grant <= '0;
      end else if (grant_fire) begin
         last_grant <= winner;
      end
   end
`endif

   // Scan downwards so the candidate closest to the search start is written last and wins.
   always_comb begin : p_pick
      int cand;
      winner = '0;
      cand   = 0;
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
`ifdef UART_TX_ARB_ROUND_ROBIN_EN
         cand = int'(last_grant) + 1 + i;
         if (cand >= NUM_REQ) begin
            cand = cand - NUM_REQ;
         end
`else
         cand = i;
`endif
         if (pending[IDXW'(cand)]) begin
            winner = IDXW'(cand);
         end
      end
   end

   // A completion pulse holds off the next grant for one cycle, giving an idle gap between writes.
   always_comb begin
      state_nx    = state;
      grant_fire  = 1'b0;
      finish_fire = 1'b0;
      case (state)
         S_IDLE: begin
            if ((|pending) && !(|o_done)) begin
               grant_fire = 1'b1;
               state_nx   = S_ISSUE;
            end
         end
         S_ISSUE: begin
            state_nx = S_WAIT;
         end
         S_WAIT: begin
            if (i_wr_finish) begin
               finish_fire = 1'b1;
               state_nx    = S_IDLE;
            end
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      pending_nx = pending;
      overrun_nx = o_overrun;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (i_req[k]) begin
            if (pending[k]) begin
               overrun_nx[k] = 1'b1;
            end else begin
               pending_nx[k] = 1'b1;
            end
         end
      end
      if (grant_fire) begin
         pending_nx[winner] = 1'b0;
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         pending   <= '0;
         o_overrun <= '0;
         for (int k = 0; k < NUM_REQ; k++) begin
            hold[k] <= '0;
         end
      end else begin
         pending   <= pending_nx;
         o_overrun <= overrun_nx;
         for (int k = 0; k < NUM_REQ; k++) begin
            if (i_req[k] && !pending[k]) begin
               hold[k] <= i_data[k*DATA_OUT_BUS_SIZE +: DATA_OUT_BUS_SIZE];
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         o_wr      <= 1'b0;
         o_wr_data <= '0;
         o_grant   <= '0;
         o_done    <= '0;
      end else begin
         o_wr   <= grant_fire;
         o_done <= '0;
         if (grant_fire) begin
            o_grant   <= NUM_REQ'(1) << winner;
            o_wr_data <= hold[winner];
         end
         if (finish_fire) begin
            o_done  <= o_grant;
            o_grant <= '0;
         end
      end
   end

   assign o_busy = (state != S_IDLE);

endmodule
`default_nettype wire
